// File: rtl/tlb_pkg.sv
// ---- tlb_pkg : shared TLB constants, op codes and sequencer states -- rev 1.0 ----
`default_nettype none

package tlb_pkg;

  localparam int TLB_ENTRIES = 16;
  localparam int TLB_IDX_W   = 4;
  localparam int TLB_VPN_W   = 19;
  localparam int TLB_ASID_W  = 8;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'b00,
    OP_TLBR  = 2'b01,
    OP_TLBWI = 2'b10,
    OP_TLBWR = 2'b11
  } tlb_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROBE = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } tlb_state_e;

endpackage

`default_nettype wire

// File: rtl/tlb_random_ctr.sv
// ---- tlb_random_ctr : CP0 Random, free-running down counter wrapping above Wired -- rev 1.0 ----
`default_nettype none

module tlb_random_ctr
  import tlb_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES,
  parameter int IDX_W   = TLB_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] wired,
  output logic [IDX_W-1:0] random_out
);

  localparam logic [IDX_W-1:0] TOP = IDX_W'(ENTRIES - 1);

  logic [IDX_W-1:0] random_d, random_q;

  // Wired >= TOP makes the wrap condition always true, so the counter parks at TOP.
  always_comb begin
    if ((random_q <= wired) || (random_q == '0)) random_d = TOP;
    else                                         random_d = random_q - IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) random_q <= TOP;
    else     random_q <= random_d;
  end

  assign random_out = random_q;

endmodule

`default_nettype wire

// File: rtl/tlb_op_ctrl.sv
// ---- tlb_op_ctrl : TLBP/TLBR/TLBWI/TLBWR sequencer driving the TLB array port -- rev 1.0 ----
`default_nettype none

module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES,
  parameter int IDX_W   = TLB_IDX_W,
  parameter int VPN_W   = TLB_VPN_W,
  parameter int ASID_W  = TLB_ASID_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [1:0]        op_code,
  input  logic [VPN_W-1:0]  entryhi_vpn,
  input  logic [ASID_W-1:0] entryhi_asid,
  input  logic [IDX_W-1:0]  index_q,
  input  logic [IDX_W-1:0]  wired,
  input  logic [VPN_W-1:0]  tlb_vpn,
  input  logic [ASID_W-1:0] tlb_asid,
  input  logic              tlb_g,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  tlb_addr,
  output logic              tlb_rd,
  output logic              tlb_we,
  output logic              p_out,
  output logic [IDX_W-1:0]  index_out,
  output logic              idx_upd,
  output logic [IDX_W-1:0]  random_out
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

  tlb_state_e        state_d, state_q;
  tlb_op_e           op_d, op_q;
  logic [VPN_W-1:0]  vpn_d, vpn_q;
  logic [ASID_W-1:0] asid_d, asid_q;
  logic [IDX_W-1:0]  lidx_d, lidx_q;
  logic [IDX_W-1:0]  addr_d, addr_q;
  logic [IDX_W-1:0]  pidx_d, pidx_q;
  logic              rd_d, rd_q, we_d, we_q, done_d, done_q, upd_d, upd_q, p_d, p_q;
  logic              match;

  tlb_random_ctr #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_random (
    .clk        (clk),
    .rst        (rst),
    .wired      (wired),
    .random_out (random_out)
  );

  // During PROBE the address register doubles as the scan counter.
  assign match = (tlb_vpn == vpn_q) && (tlb_g || (tlb_asid == asid_q));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    vpn_d   = vpn_q;
    asid_d  = asid_q;
    lidx_d  = lidx_q;
    addr_d  = addr_q;
    pidx_d  = pidx_q;
    p_d     = p_q;
    rd_d    = 1'b0;
    we_d    = 1'b0;
    done_d  = 1'b0;
    upd_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          op_d   = tlb_op_e'(op_code);
          vpn_d  = entryhi_vpn;
          asid_d = entryhi_asid;
          lidx_d = index_q;
          case (tlb_op_e'(op_code))
            OP_TLBP:  begin state_d = ST_PROBE; addr_d = '0;         rd_d = 1'b1; end
            OP_TLBR:  begin state_d = ST_READ;  addr_d = index_q;    rd_d = 1'b1; end
            OP_TLBWI: begin state_d = ST_WRITE; addr_d = index_q;    we_d = 1'b1; end
            default:  begin state_d = ST_WRITE; addr_d = random_out; we_d = 1'b1; end
          endcase
        end
      end
      ST_PROBE: begin
        if (match) begin
          pidx_d  = addr_q;
          p_d     = 1'b0;
          state_d = ST_DONE;
          done_d  = 1'b1;
          upd_d   = 1'b1;
        end else if (addr_q == LAST) begin
          pidx_d  = lidx_q;
          p_d     = 1'b1;
          state_d = ST_DONE;
          done_d  = 1'b1;
          upd_d   = 1'b1;
        end else begin
          addr_d = addr_q + IDX_W'(1);
          rd_d   = 1'b1;
        end
      end
      ST_READ, ST_WRITE: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        upd_d   = (op_q == OP_TLBP);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_TLBP;
      vpn_q   <= '0;
      asid_q  <= '0;
      lidx_q  <= '0;
      addr_q  <= '0;
      pidx_q  <= '0;
      p_q     <= 1'b0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vpn_q   <= vpn_d;
      asid_q  <= asid_d;
      lidx_q  <= lidx_d;
      addr_q  <= addr_d;
      pidx_q  <= pidx_d;
      p_q     <= p_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      done_q  <= done_d;
      upd_q   <= upd_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign tlb_addr  = addr_q;
  assign tlb_rd    = rd_q;
  assign tlb_we    = we_q;
  assign p_out     = p_q;
  assign index_out = pidx_q;
  assign idx_upd   = upd_q;

endmodule

`default_nettype wire

// File: tb/tb_tlb_op_ctrl.sv
// ---- tb_tlb_op_ctrl : directed bench with a transaction-level model of tlb_op_ctrl -- rev 1.0 ----
`default_nettype none

module tb_tlb_op_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic [18:0] ehi_vpn = '0;
  logic [7:0]  ehi_asid = '0;
  logic [3:0]  idx_in = '0;
  logic [3:0]  wired = '0;
  logic [18:0] tlb_vpn;
  logic [7:0]  tlb_asid;
  logic        tlb_g;
  logic        busy, done, tlb_rd, tlb_we, p_out, idx_upd;
  logic [3:0]  tlb_addr, index_out, random_out;

  logic [18:0] mem_vpn [16];
  logic [7:0]  mem_asid[16];
  logic        mem_g   [16];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign tlb_vpn  = mem_vpn[tlb_addr];
  assign tlb_asid = mem_asid[tlb_addr];
  assign tlb_g    = mem_g[tlb_addr];

  tlb_op_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .entryhi_vpn(ehi_vpn), .entryhi_asid(ehi_asid), .index_q(idx_in), .wired(wired),
    .tlb_vpn(tlb_vpn), .tlb_asid(tlb_asid), .tlb_g(tlb_g),
    .busy(busy), .done(done), .tlb_addr(tlb_addr), .tlb_rd(tlb_rd), .tlb_we(tlb_we),
    .p_out(p_out), .index_out(index_out), .idx_upd(idx_upd), .random_out(random_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int find_hit(input logic [18:0] vpn, input logic [7:0] asid);
    for (int i = 0; i < 16; i++)
      if (mem_vpn[i] == vpn && (mem_g[i] || mem_asid[i] == asid)) return i;
    return -1;
  endfunction

  // Model: m_cyc counts cycles since accept (0 = idle), m_lat is the cycle that carries done.
  int         m_cyc = 0, m_lat = 0, m_op = 0, m_hit = -1;
  int         m_idx = 0, m_rsel = 0, m_rnd = 15;
  logic       m_p = 1'b0;
  logic [3:0] m_index = '0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_upd", idx_upd, 0);
      check("rst_we", tlb_we, 0);
      check("rst_rd", tlb_rd, 0);
      check("rst_random", random_out, 15);
      m_cyc = 0; m_rnd = 15; m_p = 1'b0; m_index = '0;
    end else begin
      logic e_done, e_rd, e_we;
      int   e_addr;
      e_done = (m_cyc != 0) && (m_cyc == m_lat);
      e_rd   = (m_op == 0) ? (m_cyc >= 1 && m_cyc <= m_lat - 1) : (m_op == 1 && m_cyc == 1);
      e_we   = (m_op >= 2) && (m_cyc == 1);
      e_addr = (m_op == 0) ? m_cyc - 1 : (m_op == 3 ? m_rsel : m_idx);
      check("busy", busy, m_cyc != 0);
      check("done", done, e_done);
      check("idx_upd", idx_upd, e_done && m_op == 0);
      check("tlb_rd", tlb_rd, e_rd);
      check("tlb_we", tlb_we, e_we);
      if (e_rd || e_we) check("tlb_addr", tlb_addr, e_addr);
      check("p_out", p_out, m_p);
      check("index_out", index_out, m_index);
      check("random", random_out, m_rnd);
      if (m_cyc == 0) begin
        if (op_valid) begin
          m_op   = op_code;
          m_idx  = idx_in;
          m_rsel = m_rnd;
          m_hit  = find_hit(ehi_vpn, ehi_asid);
          m_lat  = (m_op != 0) ? 2 : (m_hit >= 0 ? m_hit + 2 : 17);
          m_cyc  = 1;
        end
      end else if (m_cyc == m_lat) m_cyc = 0;
      else m_cyc++;
      if (m_cyc != 0 && m_cyc == m_lat && m_op == 0) begin
        m_p     = (m_hit < 0);
        m_index = (m_hit < 0) ? 4'(m_idx) : 4'(m_hit);
      end
      m_rnd = (m_rnd <= int'(wired) || m_rnd == 0) ? 15 : m_rnd - 1;
    end
  end

  // Returns latency (accept cycle to done cycle) and the port state of the first cycle after accept.
  task automatic run_op(input logic [1:0] code, output int lat,
                        output logic [3:0] c1_addr, output logic c1_rd, output logic c1_we);
    op_valid = 1'b1; op_code = code;
    @(posedge clk); #1 op_valid = 1'b0;
    c1_addr = tlb_addr; c1_rd = tlb_rd; c1_we = tlb_we;
    lat = 1;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!done) check("done_timeout", 1, 0);
  endtask

  int          lat, n;
  logic [3:0]  a1;
  logic        r1, w1;
  logic [3:0]  rseq[4];

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_vpn[i] = 19'h100 + 19'(i); mem_asid[i] = 8'(i); mem_g[i] = 1'b0;
    end
    mem_vpn[3] = 19'h1234; mem_asid[3] = 8'd4;
    mem_vpn[6] = 19'h1234; mem_asid[6] = 8'd3;
    mem_vpn[2] = 19'h55;   mem_asid[2] = 8'd9; mem_g[2] = 1'b1;
    mem_vpn[9] = 19'h55;   mem_asid[9] = 8'd1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_random_lit", random_out, 15);
    check("reset_index_lit", index_out, 0);
    @(posedge clk); #1;

    ehi_vpn = 19'h1234; ehi_asid = 8'd3; idx_in = 4'd0;
    run_op(2'b00, lat, a1, r1, w1);
    check("hit_latency_lit", lat, 8);
    check("hit_index_lit", index_out, 6);
    check("hit_p_lit", p_out, 0);
    check("hit_upd_lit", idx_upd, 1);
    @(posedge clk); #1;

    ehi_vpn = 19'h55; ehi_asid = 8'd1;
    run_op(2'b00, lat, a1, r1, w1);
    check("dup_latency_lit", lat, 4);
    check("dup_index_lit", index_out, 2);
    @(posedge clk); #1;

    ehi_vpn = 19'h7777; idx_in = 4'd11;
    run_op(2'b00, lat, a1, r1, w1);
    check("miss_latency_lit", lat, 17);
    check("miss_p_lit", p_out, 1);
    check("miss_index_lit", index_out, 11);
    @(posedge clk); #1;

    idx_in = 4'd4;
    run_op(2'b10, lat, a1, r1, w1);
    check("tlbwi_addr_lit", a1, 4);
    check("tlbwi_we_lit", w1, 1);
    check("tlbwi_upd_lit", idx_upd, 0);
    check("tlbwi_latency_lit", lat, 2);
    @(posedge clk); #1;
    run_op(2'b01, lat, a1, r1, w1);
    check("tlbr_addr_lit", a1, 4);
    check("tlbr_rd_lit", r1, 1);
    @(posedge clk); #1;

    wired = 4'd12;
    n = 0;
    while (random_out != 4'd15 && n < 40) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; rseq[i] = random_out; end
    check("rnd_seq0_lit", rseq[0], 14);
    check("rnd_seq1_lit", rseq[1], 13);
    check("rnd_seq2_lit", rseq[2], 12);
    check("rnd_seq3_lit", rseq[3], 15);
    n = 0;
    while (random_out != 4'd13 && n < 40) begin @(posedge clk); #1; n++; end
    check("rnd_wait13", random_out, 13);
    run_op(2'b11, lat, a1, r1, w1);
    check("tlbwr_addr_lit", a1, 13);
    check("tlbwr_we_lit", w1, 1);
    @(posedge clk); #1;

    wired = 4'd15;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) begin #1 check("rnd_hold15_lit", random_out, 15); @(posedge clk); end
    #1 wired = 4'd0;

    ehi_vpn = 19'h7777; idx_in = 4'd7;
    op_valid = 1'b1; op_code = 2'b00;
    @(posedge clk); #1 op_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("midprobe_scan_lit", tlb_addr, 5);
    rst = 1'b1;
    #1 check("midrst_busy_lit", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (idx_upd || done) n++; end
    check("post_rst_pulses_lit", n, 0);

    idx_in = 4'd9;
    run_op(2'b01, lat, a1, r1, w1);
    check("recover_tlbr_addr_lit", a1, 9);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
